// File: rtl/lsu_align_seq.sv
// Splits misaligned byte/half/word loads and stores into aligned single-port RAM beats; response 3 cycles (aligned), 4 (split), 2 (error) after handshake.
// Accepts only in IDLE, no response backpressure; define LSU_MISALIGN_TRAP_EN to trap would-split requests instead of splitting them.
module lsu_align_seq #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_wren,
  input  logic              i_req_signed,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wren,
  output logic [3:0]        o_mem_bmask,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [CNT_W-1:0]  o_split_cnt
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                wren_q, wren_d;
  logic                signed_q, signed_d;
  logic                split_q, split_d;
  logic                err_q, err_d;
  logic [31:0]         lo_q, lo_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    split_cnt_q, split_cnt_d;

  logic [1:0]          off;
  logic [ADDR_W-1:0]   word0, word1;
  logic [3:0]          mask4;
  logic [7:0]          mask8;
  logic [63:0]         lane_wdata;
  logic [31:0]         load_word;
  logic [31:0]         load_ext;
  logic                req_oor, req_split;

  assign off        = addr_q[1:0];
  assign word0      = addr_q[ADDR_W+1:2];
  assign word1      = word0 + ADDR_W'(1);
  assign lane_wdata = {32'h0, wdata_q} << {off, 3'b000};
  assign mask8      = {4'h0, mask4} << off;
  assign req_oor    = |i_req_addr[31:ADDR_W+2];

  always_comb begin
    mask4 = 4'b1111;
    if (size_q == 2'b00) mask4 = 4'b0001;
    else if (size_q == 2'b01) mask4 = 4'b0011;
  end

  // Halves only straddle at offset 3; words straddle at any nonzero offset.
  always_comb begin
    req_split = 1'b0;
    if (i_req_size == 2'b01) req_split = (i_req_addr[1:0] == 2'b11);
    else if (i_req_size[1]) req_split = (i_req_addr[1:0] != 2'b00);
  end

  // In DONE the current read data is the high word of a split, or the only word otherwise.
  always_comb begin
    load_word = 32'(({split_q ? i_mem_rdata : 32'h0, split_q ? lo_q : i_mem_rdata}) >> {off, 3'b000});
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & load_word[7]}}, load_word[7:0]};
      2'b01:   load_ext = {{16{signed_q & load_word[15]}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    wren_d      = wren_q;
    signed_d    = signed_q;
    split_d     = split_q;
    err_d       = err_q;
    lo_d        = lo_q;
    split_cnt_d = split_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wren  = 1'b0;
    o_mem_bmask = 4'h0;
    o_mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (i_req_valid && ready_q) begin
          addr_d   = i_req_addr[ADDR_W+1:0];
          wdata_d  = i_req_wdata;
          size_d   = i_req_size;
          wren_d   = i_req_wren;
          signed_d = i_req_signed;
`ifdef LSU_MISALIGN_TRAP_EN
          split_d  = 1'b0;
          err_d    = req_oor | req_split;
          if (req_split && !req_oor && split_cnt_q != '1) split_cnt_d = split_cnt_q + CNT_W'(1);
`else
          split_d  = req_split;
          err_d    = req_oor;
`endif
          state_d  = err_d ? DONE : BEAT0;
        end
      end
      BEAT0: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = word0;
        o_mem_wren  = wren_q;
        o_mem_bmask = mask8[3:0];
        o_mem_wdata = lane_wdata[31:0];
        state_d     = split_q ? BEAT1 : DONE;
      end
      BEAT1: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = word1;
        o_mem_wren  = wren_q;
        o_mem_bmask = mask8[7:4];
        o_mem_wdata = lane_wdata[63:32];
        lo_d        = i_mem_rdata;
        if (split_cnt_q != '1) split_cnt_d = split_cnt_q + CNT_W'(1);
        state_d     = DONE;
      end
      default: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (err_q || wren_q) ? 32'h0 : load_ext;
        state_d     = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      wren_q      <= 1'b0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      lo_q        <= 32'h0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      wren_q      <= wren_d;
      signed_q    <= signed_d;
      split_q     <= split_d;
      err_q       <= err_d;
      lo_q        <= lo_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_split_cnt = split_cnt_q;

endmodule
